// File: rtl/sipo_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register; flags overrun when a word arrives
// while the previous one is still unconsumed.
module rx_out_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             din_perr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_perr,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_perr  <= 1'b0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                // A same-cycle handshake frees the slot for the incoming word
                if (!dout_valid || dout_ready) begin
                    dout       <= din;
                    dout_perr  <= din_perr;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits, optional
// even parity, stop bit; completed words go to a one-entry output buffer.
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          PARITY_EN = 1'b1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_perr,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sr, sr_shift;
    logic             perr;
    logic             word_done, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        word_done = 1'b0;
        stop_bad  = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE:   if (sin == START_BIT) state_nx = DATA;
                DATA:   if (cnt == LAST_BIT)  state_nx = PARITY_EN ? PARITY : STOP;
                PARITY: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    if (sin == STOP_BIT) word_done = 1'b1;
                    else                 stop_bad  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], sin};
        else           sr_shift = {sin, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sr        <= '0;
            perr      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (bit_en) begin
                case (state)
                    IDLE: if (sin == START_BIT) begin
                        cnt  <= '0;
                        perr <= 1'b0;
                    end
                    DATA: begin
                        sr  <= sr_shift;
                        cnt <= cnt + 1'b1;
                    end
                    PARITY: perr <= (^sr) ^ sin;
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    rx_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (word_done),
        .din        (sr),
        .din_perr   (PARITY_EN ? perr : 1'b0),
        .dout       (dout),
        .dout_perr  (dout_perr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    // A framing error never loads the buffer, so the two pulses are exclusive
    a_err_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_err && overrun));

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed frames plus randomized
// traffic against a frame-level reference model.
module tb_sipo_frame_rx;
    import sipo_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             sin = 1'b1;
    logic             bit_en = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_perr, dout_valid, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 1;

    logic [WIDTH-1:0] m_word = '0;
    logic             m_perr = 1'b0, m_valid = 1'b0, m_ferr = 1'b0;
    logic             m_ovr = 1'b0, m_busy = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_rx #(
        .WIDTH     (WIDTH),
        .PARITY_EN (1'b1),
        .MSB_FIRST (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_perr  (dout_perr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("dout",       32'(dout),       32'(m_word));
        check("dout_perr",  32'(dout_perr),  32'(m_perr));
        check("frame_err",  32'(frame_err),  32'(m_ferr));
        check("overrun",    32'(overrun),    32'(m_ovr));
        check("busy",       32'(busy),       32'(m_busy));
    endtask

    task automatic model_clear();
        m_word = '0; m_perr = 1'b0; m_valid = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0; m_busy = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later
    task automatic cycle(input logic s, input logic en, input logic busy_after,
                         input logic stop_strobe, input logic [WIDTH-1:0] word,
                         input logic word_perr);
        logic done;
        sin    = s;
        bit_en = en;
        case (rdy_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            done   = en && stop_strobe && (s == STOP_BIT);
            m_ferr = en && stop_strobe && (s != STOP_BIT);
            m_ovr  = 1'b0;
            if (done) begin
                if (!m_valid || dout_ready) begin
                    m_word  = word;
                    m_perr  = word_perr;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
            m_busy = busy_after;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        logic en;
        for (int i = 0; i < n; i++) begin
            en = 1'($urandom_range(0, 1));
            cycle(en ? IDLE_LEVEL : 1'($urandom_range(0, 1)), en, 1'b0, 1'b0, '0, 1'b0);
        end
    endtask

    // Frame slots: start, data LSB first, even parity (optionally flipped), stop.
    // Non-strobe cycles carry random line noise that must be ignored.
    task automatic send_frame(input logic [WIDTH-1:0] data, input logic bad_par,
                              input logic stop_v, input int gap, input int n_slots);
        logic slots[$];
        int   last;
        slots.push_back(START_BIT);
        for (int i = 0; i < int'(WIDTH); i++) slots.push_back(data[i]);
        slots.push_back((^data) ^ bad_par);
        slots.push_back(stop_v);
        last = slots.size() - 1;
        for (int k = 0; k < n_slots && k <= last; k++) begin
            for (int g = 1; g < gap; g++)
                cycle(1'($urandom_range(0, 1)), 1'b0, m_busy, 1'b0, data, bad_par);
            cycle(slots[k], 1'b1, (k == last) ? 1'b0 : 1'b1, k == last, data, bad_par);
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        model_clear();
        #1 check_all();
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;

        rdy_mode = 1;
        send_frame(8'hA5, 1'b0, 1'b1, 1, 99);
        idle(2);
        send_frame(8'hA5, 1'b1, 1'b1, 1, 99);
        idle(2);
        send_frame(8'hA5, 1'b0, 1'b0, 1, 99);
        idle(2);

        rdy_mode = 0;
        send_frame(8'h3C, 1'b0, 1'b1, 1, 99);
        send_frame(8'hC3, 1'b0, 1'b1, 1, 99);
        idle(2);
        rdy_mode = 1;
        idle(2);

        send_frame(8'h5A, 1'b0, 1'b1, 4, 99);
        idle(2);

        // Abort after start + 4 data bits
        send_frame(8'h96, 1'b0, 1'b1, 1, 5);
        rst_n = 1'b0;
        model_clear();
        #1 check_all();
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        rst_n = 1'b1;
        idle(1);
        send_frame(8'hFF, 1'b0, 1'b1, 1, 99);
        idle(2);

        rdy_mode = 2;
        for (int f = 0; f < 150; f++) begin
            send_frame(WIDTH'($urandom), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 5) != 0, $urandom_range(1, 3), 99);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        rdy_mode = 1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-to-parallel frame receiver: the receive end of the single-bit serial shift path that the SISO/PISO shift-register blocks drive.
- Detects a start bit on the serial line and shifts in WIDTH data bits, an optional even-parity bit and a stop bit.
- Presents each completed word on a one-entry valid/ready output buffer.
- Sits between the serial link and the parallel consumer logic.

Parameters:
- WIDTH, 8, data bits per frame (2..32).
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.
- MSB_FIRST, 0, 0 = the first data bit received is dout[0]; 1 = the first data bit received is dout[WIDTH-1].

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- sin, input, 1, serial data line; idles high.
- bit_en, input, 1, sample strobe; sin is sampled only on cycles with bit_en=1.
- dout, output, WIDTH, received word.
- dout_perr, output, 1, parity-error flag travelling with dout.
- dout_valid, output, 1, dout and dout_perr hold a word.
- dout_ready, input, 1, consumer accepts the word when dout_valid=1 and dout_ready=1.
- frame_err, output, 1, one-cycle pulse: stop bit sampled low.
- overrun, output, 1, one-cycle pulse: a completed word was dropped because the buffer was full.
- busy, output, 1, high when the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; bit counter and shift register clear.
  - dout=0, dout_perr=0, dout_valid=0, frame_err=0, overrun=0, busy=0.
  - Asserting reset mid-frame discards the partial frame.
- All state advances only on cycles where bit_en=1; with bit_en=0 the FSM holds.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on bit_en with sin=0 (start bit), clear the counter and go to DATA. sin=1 stays in IDLE.
  - DATA: on each bit_en, shift sin in and increment the counter.
    - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
    - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
    - After the WIDTH-th bit: go to PARITY if PARITY_EN=1, otherwise to STOP.
  - PARITY: on bit_en, latch perr = (^sr) ^ sin (even parity: 1 = error), then go to STOP.
  - STOP: on bit_en, always return to IDLE.
    - sin=1: the frame is complete; hand the word to the output buffer.
    - sin=0: pulse frame_err for one cycle and discard the word (no buffer update).
- Output buffer (one entry):
  - On frame completion, if dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle: load dout<=sr, dout_perr<=perr (0 when PARITY_EN=0), and set dout_valid=1 on the next edge.
  - On frame completion with dout_valid=1 and dout_ready=0: pulse overrun for one cycle; the new word is dropped and the old word is kept unchanged.
  - Consumption (dout_valid and dout_ready, no simultaneous load): dout_valid clears on the next edge. dout keeps its last value.
  - dout and dout_perr are stable while dout_valid=1 and no handshake occurs.
- Latency: dout_valid rises on the clock edge at which the stop-bit bit_en is sampled, i.e. visible in the cycle after the stop-bit strobe cycle.
- A new start bit may be accepted on the first bit_en after STOP (back-to-back frames, no extra idle bit required).
- A glitch low in IDLE without bit_en is ignored.
- busy=1 in DATA, PARITY and STOP.
- frame_err and overrun are never asserted in the same cycle, because a framing error never loads the buffer.

Decomposition:
- Shared package sipo_pkg:
  - FSM state enum: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- The one natural sub-module is rx_out_buf: the one-entry valid/ready holding register with overrun detection, reusable by later parallel-output blocks.
- The FSM, counter and shift register stay in the top level.

Test Plan:
- WIDTH=8, PARITY_EN=1, MSB_FIRST=0, bit_en every cycle. Send start, data bits 1,0,1,0,0,1,0,1, parity 0, stop 1, with dout_ready=1 -> dout=8'hA5, dout_perr=0, dout_valid high for 1 cycle, the cycle after the stop strobe.
- Same frame but parity bit 1 -> dout=8'hA5, dout_perr=1, frame_err=0.
- Same frame with stop bit 0 -> frame_err pulses for 1 cycle, dout_valid stays 0, FSM back in IDLE (busy=0).
- Two back-to-back frames 8'h3C then 8'hC3 with dout_ready=0 -> first word held (dout=8'h3C, dout_valid=1), overrun pulses at the second stop strobe. Then raise dout_ready -> 8'h3C is consumed and dout_valid drops.
- bit_en asserted one cycle in four during a frame of 8'h5A -> result identical to the every-cycle case; FSM holds on non-strobe cycles.
- Assert rst_n=0 after the 4th data bit, release, then send a full frame of 8'hFF -> no output from the aborted frame, dout=8'hFF delivered cleanly, all outputs 0 during reset.
